// File: rtl/uart_rx_fifo_feeder_pkg.sv
// uart_rx_pkg: FSM state type and frame timing constants shared by the UART receive path
// Build option UART_RX_MAJORITY_EN: 2-of-3 bit vote over ticks 6/7/8, decision moved to tick 8
package uart_rx_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_e;
  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_TICK = 7;
  localparam int DATA_BITS = 8;
`ifdef UART_RX_MAJORITY_EN
  localparam int DECIDE_TICK = SAMPLE_TICK + 1;
`else
  localparam int DECIDE_TICK = SAMPLE_TICK;
`endif
endpackage

// File: rtl/uart_rx_fifo_feeder_if.sv
// uart_rx_fifo_feeder_if: byte write port of the receive FIFO
// master (receiver): drives wr_en/wr_data, sees wr_full/almost_full; slave: the FIFO side
interface uart_rx_fifo_feeder_if;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       wr_full;
  logic       almost_full;
  modport master (output wr_en, wr_data, input wr_full, almost_full);
  modport slave (input wr_en, wr_data, output wr_full, almost_full);
endinterface

// File: rtl/uart_rx_fifo_feeder_tick_gen.sv
// uart_rx_tick_gen: oversample prescaler, one-cycle tick every OVS_DIV clocks
// Ports: clk, rst_n (async active-low), clr (sync restart, suppresses tick), tick
module uart_rx_tick_gen #(
  parameter int unsigned OVS_DIV = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  logic [15:0] cnt_q, cnt_d;
  assign tick = !clr && cnt_q == 16'(OVS_DIV - 1);
  always_comb cnt_d = (clr || tick) ? '0 : cnt_q + 16'd1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/uart_rx_fifo_feeder.sv
// uart_rx_fifo_feeder: 8N1 16x-oversampled UART receiver pushing bytes into the receive FIFO
// Ports: clk, rst_n (async active-low), rxd (async line), fifo (FIFO write port, master),
//        rts_n (registered flow control), frame_err/overrun_err (pulses), drop_cnt (saturating)
// Build option UART_RX_MAJORITY_EN: majority-voted bit sampling
module uart_rx_fifo_feeder
  import uart_rx_pkg::*;
#(
  parameter int unsigned OVS_DIV = 27
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rxd,
  uart_rx_fifo_feeder_if.master fifo,
  output logic                  rts_n,
  output logic                  frame_err,
  output logic                  overrun_err,
  output logic [15:0]           drop_cnt
);
  localparam int OW = $clog2(OVERSAMPLE);
  logic sync_q, rxd_s_q;
  state_e state_q, state_d;
  logic [OW-1:0] os_q, os_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d, wr_data_q, wr_data_d;
  logic wr_en_q, wr_en_d, rts_n_q, rts_n_d, frame_q, frame_d, ovr_q, ovr_d;
  logic [15:0] drop_q, drop_d;
  logic tick, clr, dec, samp;
  // a low line in IDLE restarts the prescaler so ticks align to the start edge
  assign clr = state_q == IDLE && !rxd_s_q;
  uart_rx_tick_gen #(.OVS_DIV(OVS_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .tick (tick)
  );
  assign dec = tick && os_q == OW'(DECIDE_TICK);
`ifdef UART_RX_MAJORITY_EN
  logic s6_q, s6_d, s7_q, s7_d;
  always_comb begin
    s6_d = (tick && os_q == OW'(DECIDE_TICK - 2)) ? rxd_s_q : s6_q;
    s7_d = (tick && os_q == OW'(DECIDE_TICK - 1)) ? rxd_s_q : s7_q;
  end
  assign samp = (s6_q & s7_q) | (s6_q & rxd_s_q) | (s7_q & rxd_s_q);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s6_q <= 1'b1;
      s7_q <= 1'b1;
    end else begin
      s6_q <= s6_d;
      s7_q <= s7_d;
    end
`else
  assign samp = rxd_s_q;
`endif
  always_comb begin
    state_d   = state_q;
    os_d      = tick ? os_q + 1'b1 : os_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    frame_d   = 1'b0;
    ovr_d     = 1'b0;
    drop_d    = drop_q;
    rts_n_d   = fifo.almost_full | fifo.wr_full;
    case (state_q)
      IDLE: if (!rxd_s_q) begin
        state_d = START;
        os_d    = '0;
      end
      START: if (dec) begin
        state_d = samp ? IDLE : DATA;
        bit_d   = '0;
      end
      DATA: if (dec) begin
        shift_d = {samp, shift_q[7:1]};
        bit_d   = bit_q + 3'd1;
        state_d = bit_q == 3'(DATA_BITS - 1) ? STOP : DATA;
      end
      STOP: if (dec) begin
        state_d   = samp ? IDLE : WAIT_HIGH;
        frame_d   = !samp;
        ovr_d     = samp && fifo.wr_full;
        wr_en_d   = samp && !fifo.wr_full;
        wr_data_d = (samp && !fifo.wr_full) ? shift_q : wr_data_q;
        drop_d    = drop_q + {15'd0, samp && fifo.wr_full && drop_q != 16'hFFFF};
      end
      WAIT_HIGH: if (rxd_s_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q    <= 1'b1;
      rxd_s_q   <= 1'b1;
      state_q   <= IDLE;
      os_q      <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      rts_n_q   <= 1'b1;
      frame_q   <= 1'b0;
      ovr_q     <= 1'b0;
      drop_q    <= '0;
    end else begin
      sync_q    <= rxd;
      rxd_s_q   <= sync_q;
      state_q   <= state_d;
      os_q      <= os_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      rts_n_q   <= rts_n_d;
      frame_q   <= frame_d;
      ovr_q     <= ovr_d;
      drop_q    <= drop_d;
    end
  assign fifo.wr_en   = wr_en_q;
  assign fifo.wr_data = wr_data_q;
  assign rts_n        = rts_n_q;
  assign frame_err    = frame_q;
  assign overrun_err  = ovr_q;
  assign drop_cnt     = drop_q;
endmodule

// File: tb/tb_uart_rx_fifo_feeder.sv
// tb_uart_rx_fifo_feeder: directed and random frames checked against a byte-level model
module tb_uart_rx_fifo_feeder;
  import uart_rx_pkg::*;
  localparam int OVS = 4;
  localparam int BIT = 64;
  logic clk = 1'b0;
  logic rst_n, rxd, rts_n, frame_err, overrun_err;
  logic [15:0] drop_cnt;
  uart_rx_fifo_feeder_if fif ();
  uart_rx_fifo_feeder #(.OVS_DIV(OVS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxd        (rxd),
    .fifo       (fif),
    .rts_n      (rts_n),
    .frame_err  (frame_err),
    .overrun_err(overrun_err),
    .drop_cnt   (drop_cnt)
  );
  always #5 clk = ~clk;
  int tests = 0, fails = 0, fe_cnt = 0, ov_cnt = 0, dbl = 0;
  longint cyc = 0, edge_t = 0;
  logic prev_en = 1'b0;
  logic [7:0] got_q[$];
  longint got_t[$];
  always @(negedge clk) begin
    cyc++;
    if (fif.wr_en === 1'b1) begin
      got_q.push_back(fif.wr_data);
      got_t.push_back(cyc);
    end
    if (frame_err === 1'b1) fe_cnt++;
    if (overrun_err === 1'b1) ov_cnt++;
    if (fif.wr_en === 1'b1 && prev_en) dbl++;
    prev_en = (fif.wr_en === 1'b1);
  end
  task automatic chk(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic clear();
    got_q.delete();
    got_t.delete();
  endtask
  // whole 10-bit frame; gk >= 0 inverts rxd for one tick centred on tick 16*gk+7
  task automatic send(input logic [7:0] b, input logic stop, input int gk);
    for (int i = 0; i < 10 * BIT; i++) begin
      int k;
      logic v;
      k = i / BIT;
      v = (k == 0) ? 1'b0 : (k <= 8) ? b[k-1] : stop;
      if (k == gk && i % BIT >= 31 && i % BIT < 35) v = ~v;
      if (i == 0) edge_t = cyc;
      rxd = v;
      @(negedge clk);
    end
    rxd = 1'b1;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_wr_en"}, fif.wr_en, 0);
    chk({tag, "_wr_data"}, fif.wr_data, 0);
    chk({tag, "_rts_n"}, rts_n, 1);
    chk({tag, "_frame_err"}, frame_err, 0);
    chk({tag, "_overrun_err"}, overrun_err, 0);
    chk({tag, "_drop_cnt"}, drop_cnt, 0);
  endtask
  initial begin
    logic [7:0] exp_q[$];
    logic [7:0] b;
    logic full;
    int fe0, ov0, drop_exp;
    longint lat;
    rst_n = 1'b0;
    rxd = 1'b1;
    fif.wr_full = 1'b0;
    fif.almost_full = 1'b0;
    clks(5);
    chk_reset("por");
    rst_n = 1'b1;
    clks(20);
    chk("rts_idle", rts_n, 0);
    clear();
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    send(8'hA5, 1'b1, -1);
    clks(50);
    chk("a5_writes", got_q.size(), 1);
    chk("a5_data", got_q[0], 8'hA5);
    lat = got_t[0] - edge_t;
    chk("a5_latency_in_window", longint'(lat >= 600 && lat <= 616), 1);
    chk("a5_no_frame_err", fe_cnt - fe0, 0);
    chk("a5_no_overrun", ov_cnt - ov0, 0);
    clear();
    rxd = 1'b0;
    clks(8);
    rxd = 1'b1;
    clks(200);
    chk("glitch_writes", got_q.size(), 0);
    chk("glitch_frame_err", fe_cnt - fe0, 0);
    chk("glitch_state", longint'(dut.state_q), longint'(IDLE));
    send(8'h3C, 1'b1, -1);
    clks(50);
    chk("post_glitch_writes", got_q.size(), 1);
    chk("post_glitch_data", got_q[0], 8'h3C);
    clear();
    send(8'h55, 1'b0, -1);
    rxd = 1'b0;
    clks(200);
    chk("ferr_pulses", fe_cnt - fe0, 1);
    chk("ferr_writes", got_q.size(), 0);
    rxd = 1'b1;
    clks(50);
    send(8'h81, 1'b1, -1);
    clks(50);
    chk("post_ferr_writes", got_q.size(), 1);
    chk("post_ferr_data", got_q[0], 8'h81);
    chk("post_ferr_pulses", fe_cnt - fe0, 1);
    clear();
    fif.wr_full = 1'b1;
    send(8'h3C, 1'b1, -1);
    clks(50);
    chk("ovr_pulses", ov_cnt - ov0, 1);
    chk("ovr_drop_cnt", drop_cnt, 1);
    chk("ovr_writes", got_q.size(), 0);
    chk("ovr_rts_full", rts_n, 1);
    fif.wr_full = 1'b0;
    clks(3);
    chk("rts_released", rts_n, 0);
    fif.almost_full = 1'b1;
    #1;
    chk("rts_af_rise_hold", rts_n, 0);
    @(negedge clk);
    chk("rts_af_rise", rts_n, 1);
    fif.almost_full = 1'b0;
    #1;
    chk("rts_af_fall_hold", rts_n, 1);
    @(negedge clk);
    chk("rts_af_fall", rts_n, 0);
    clear();
    send(8'h00, 1'b1, -1);
    send(8'hFF, 1'b1, -1);
    send(8'h7E, 1'b1, -1);
    clks(50);
    chk("b2b_writes", got_q.size(), 3);
    chk("b2b_data0", got_q[0], 8'h00);
    chk("b2b_data1", got_q[1], 8'hFF);
    chk("b2b_data2", got_q[2], 8'h7E);
    chk("b2b_gap01", got_t[1] - got_t[0], 640);
    chk("b2b_gap12", got_t[2] - got_t[1], 640);
    clear();
    rxd = 1'b0;
    clks(3 * BIT + 20);
    rst_n = 1'b0;
    clks(2);
    chk_reset("midrst");
    chk("midrst_state", longint'(dut.state_q), longint'(IDLE));
    rxd = 1'b1;
    clks(3);
    rst_n = 1'b1;
    clks(300);
    chk("midrst_writes", got_q.size(), 0);
    send(8'h12, 1'b1, -1);
    clks(50);
    chk("post_rst_writes", got_q.size(), 1);
    chk("post_rst_data", got_q[0], 8'h12);
    clear();
    drop_exp = 0;
    ov0 = ov_cnt;
    for (int n = 0; n < 8; n++) begin
      b = 8'($urandom);
      full = ($urandom_range(0, 3) == 0);
      fif.wr_full = full;
      send(b, 1'b1, -1);
      fif.wr_full = 1'b0;
      if (full) drop_exp++;
      else exp_q.push_back(b);
      clks($urandom_range(0, 40));
    end
    clks(50);
    chk("rnd_writes", got_q.size(), exp_q.size());
    foreach (exp_q[i]) chk($sformatf("rnd_data%0d", i), got_q[i], exp_q[i]);
    chk("rnd_drop_cnt", drop_cnt, drop_exp);
    chk("rnd_overruns", ov_cnt - ov0, drop_exp);
`ifdef UART_RX_MAJORITY_EN
    clear();
    send(8'h96, 1'b1, 0);
    send(8'hC3, 1'b1, 5);
    clks(50);
    chk("maj_writes", got_q.size(), 2);
    chk("maj_start_glitch", got_q[0], 8'h96);
    chk("maj_data_glitch", got_q[1], 8'hC3);
`endif
    chk("no_double_wr_en", dbl, 0);
    chk("total_frame_errs", fe_cnt, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
